// File: rtl/nios_cpu_nios2_oci_dct_capture_if.sv
// Trace-capture bus: OCI frame inputs, run-control levels and the drain handshake.
// The master drives frames and pulls entries; the slave is the capture buffer.
interface nios_cpu_nios2_oci_dct_capture_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
);
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              dct_valid;
  logic              test_ending;
  logic              test_has_ended;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_count;
  logic [ADDR_W:0]   fill_level;
  logic [OVF_W-1:0]  overflow_cnt;
  logic              frozen;
  logic              drained;
  logic              parity_err;

  modport slave (
    input  dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_ready,
    output rd_valid, rd_data, rd_count, fill_level, overflow_cnt, frozen, drained,
    parity_err
  );

  modport master (
    output dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_ready,
    input  rd_valid, rd_data, rd_count, fill_level, overflow_cnt, frozen, drained,
    parity_err
  );
endinterface

// File: rtl/nios_cpu_nios2_oci_dct_capture.sv
// DCT trace capture FIFO with drop counting and a CAPTURE/FREEZE/DONE run state machine.
// Optional per-entry even parity is enabled by defining NIOS_OCI_DCT_PARITY_EN.
module nios_cpu_nios2_oci_dct_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
) (
  input logic clk,
  input logic reset,
  nios_cpu_nios2_oci_dct_capture_if.slave bus
);
`ifdef NIOS_OCI_DCT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int EW = PAR_W + CNT_W + DATA_W;

  typedef enum logic [1:0] {ST_CAPTURE, ST_FREEZE, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     head_q, head_d, wr_entry;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              rd_valid_q;
  logic              frozen_q, drained_q;
  logic              wr_cand, wr_acc, rd_fire, full, drop;

`ifdef NIOS_OCI_DCT_PARITY_EN
  assign wr_entry = {^{bus.dct_count, bus.dct_buffer}, bus.dct_count, bus.dct_buffer};
`else
  assign wr_entry = {bus.dct_count, bus.dct_buffer};
`endif

  assign full    = (fill_q == (ADDR_W+1)'(DEPTH));
  assign rd_fire = rd_valid_q && bus.rd_ready;
  assign wr_cand = bus.dct_valid && (bus.dct_count != '0) && (state_q == ST_CAPTURE);
  // A full FIFO still takes the frame when the head leaves on the same edge.
  assign wr_acc  = wr_cand && (!full || rd_fire);
  assign drop    = wr_cand && !wr_acc;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, rd_fire};
    fill_d   = fill_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_fire};
    ovf_d    = (drop && (ovf_q != '1)) ? ovf_q + 1'b1 : ovf_q;
    head_d   = head_q;
    // The only time the new head is the frame being written is when it lands
    // in the slot the read pointer moves onto; bypass the array then.
    if (fill_d != '0) begin
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) head_d = wr_entry;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CAPTURE: begin
        if (bus.test_has_ended && (fill_d == '0))        state_d = ST_DONE;
        else if (bus.test_ending || bus.test_has_ended)  state_d = ST_FREEZE;
      end
      ST_FREEZE: if (bus.test_has_ended && (fill_d == '0)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CAPTURE;
      head_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      frozen_q   <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= (fill_d != '0);
      frozen_q   <= (state_d != ST_CAPTURE);
      drained_q  <= (state_d == ST_DONE);
    end
  end

`ifdef NIOS_OCI_DCT_PARITY_EN
  logic parity_err_q;
  // Even parity: the XOR over the whole stored word, parity bit included, is zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      parity_err_q <= 1'b0;
    else if (rd_fire && (^head_q))  parity_err_q <= 1'b1;
  end
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = head_q[DATA_W-1:0];
  assign bus.rd_count     = head_q[DATA_W +: CNT_W];
  assign bus.fill_level   = fill_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.frozen       = frozen_q;
  assign bus.drained      = drained_q;
endmodule

// File: tb/tb_nios_cpu_nios2_oci_dct_capture.sv
// Directed bench for the DCT capture FIFO: ordering, overflow, freeze/drain, reset, parity.
module tb_nios_cpu_nios2_oci_dct_capture;
  localparam int DATA_W = 30, CNT_W = 4, DEPTH = 16, ADDR_W = 4, OVF_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nios_cpu_nios2_oci_dct_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
                                      .OVF_W(OVF_W)) bus ();

  nios_cpu_nios2_oci_dct_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
                                   .ADDR_W(ADDR_W), .OVF_W(OVF_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dct_valid      = 1'b0;
    bus.dct_count      = '0;
    bus.dct_buffer     = '0;
    bus.rd_ready       = 1'b0;
    bus.test_ending    = 1'b0;
    bus.test_has_ended = 1'b0;
  endtask

  task automatic frame(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    bus.dct_valid  = 1'b1;
    bus.dct_buffer = d;
    bus.dct_count  = c;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_fill", 32'(bus.fill_level), 0);
    chk("rst_ovf", 32'(bus.overflow_cnt), 0);
    chk("rst_frozen", 32'(bus.frozen), 0);
    chk("rst_drained", 32'(bus.drained), 0);
    chk("rst_parity", 32'(bus.parity_err), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_rd_count", 32'(bus.rd_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Three frames, no reads; head visible right after the first write.
    frame(30'h1, 4'd4);
    tick();
    chk("w1_rd_valid", 32'(bus.rd_valid), 1);
    chk("w1_head", 32'(bus.rd_data), 32'h1);
    chk("w1_fill", 32'(bus.fill_level), 1);
    frame(30'h2, 4'd4); tick();
    frame(30'h3, 4'd4); tick();
    chk("w3_fill", 32'(bus.fill_level), 3);
    idle();
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("drain3_data", 32'(bus.rd_data), 32'(i));
      chk("drain3_cnt", 32'(bus.rd_count), 4);
      tick();
    end
    chk("drain3_empty", 32'(bus.rd_valid), 0);
    chk("drain3_fill", 32'(bus.fill_level), 0);

    // Twenty frames into a 16-deep FIFO: four drops.
    idle();
    for (int i = 0; i < 20; i++) begin
      frame(30'h100 + 30'(i), 4'd3);
      tick();
    end
    chk("ovf_fill", 32'(bus.fill_level), 16);
    chk("ovf_cnt", 32'(bus.overflow_cnt), 4);

    // Full FIFO with simultaneous read and write: write accepted.
    frame(30'h200, 4'd5);
    bus.rd_ready = 1'b1;
    chk("full_rw_head", 32'(bus.rd_data), 32'h100);
    tick();
    chk("full_rw_fill", 32'(bus.fill_level), 16);
    chk("full_rw_ovf", 32'(bus.overflow_cnt), 4);
    bus.dct_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("order_data", 32'(bus.rd_data), 32'h100 + 32'(i));
      tick();
    end
    chk("order_last", 32'(bus.rd_data), 32'h200);
    chk("order_last_cnt", 32'(bus.rd_count), 5);
    tick();
    chk("order_empty", 32'(bus.fill_level), 0);

    // Zero-count frames are ignored entirely.
    idle();
    for (int i = 0; i < 3; i++) begin
      frame(30'h3FF, 4'd0);
      tick();
    end
    chk("zero_fill", 32'(bus.fill_level), 0);
    chk("zero_ovf", 32'(bus.overflow_cnt), 4);

    // Freeze with 5 stored, then drain under test_has_ended.
    for (int i = 0; i < 5; i++) begin
      frame(30'h300 + 30'(i), 4'd2);
      tick();
    end
    idle();
    bus.test_ending = 1'b1;
    tick();
    bus.test_ending = 1'b0;
    chk("frz_frozen", 32'(bus.frozen), 1);
    chk("frz_drained", 32'(bus.drained), 0);
    frame(30'h3AA, 4'd2); tick();
    frame(30'h3BB, 4'd2); tick();
    chk("frz_fill", 32'(bus.fill_level), 5);
    chk("frz_ovf", 32'(bus.overflow_cnt), 4);
    idle();
    bus.test_has_ended = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("frz_drain_data", 32'(bus.rd_data), 32'h300 + 32'(i));
      chk("frz_drained_pre", 32'(bus.drained), 0);
      tick();
    end
    chk("done_drained", 32'(bus.drained), 1);
    chk("done_frozen", 32'(bus.frozen), 1);
    frame(30'h3CC, 4'd1); tick();
    chk("done_terminal_fill", 32'(bus.fill_level), 0);
    chk("done_terminal_drained", 32'(bus.drained), 1);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    idle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_ovf", 32'(bus.overflow_cnt), 0);
    chk("async_drained", 32'(bus.drained), 0);
    chk("async_frozen", 32'(bus.frozen), 0);
    reset = 1'b0;
    #1;

    // test_ending together with a write: the frame is still stored.
    frame(30'h55, 4'd7);
    bus.test_ending = 1'b1;
    tick();
    idle();
    chk("end_wr_fill", 32'(bus.fill_level), 1);
    chk("end_wr_frozen", 32'(bus.frozen), 1);
    chk("end_wr_data", 32'(bus.rd_data), 32'h55);
    frame(30'h56, 4'd7); tick();
    chk("end_wr_after", 32'(bus.fill_level), 1);

    // Direct CAPTURE -> DONE when the run ends with an empty FIFO.
    do_reset();
    bus.test_has_ended = 1'b1;
    tick();
    chk("direct_done", 32'(bus.drained), 1);
    chk("direct_frozen", 32'(bus.frozen), 1);

    // CAPTURE with test_has_ended and data present goes to FREEZE first.
    do_reset();
    frame(30'h77, 4'd1); tick();
    idle();
    bus.test_has_ended = 1'b1;
    tick();
    chk("hasend_nonempty_frozen", 32'(bus.frozen), 1);
    chk("hasend_nonempty_drained", 32'(bus.drained), 0);
    bus.rd_ready = 1'b1;
    tick();
    chk("hasend_drain_done", 32'(bus.drained), 1);
    chk("noparity_err", 32'(bus.parity_err), 0);

`ifdef NIOS_OCI_DCT_PARITY_EN
    // Corrupt the stored parity of the head entry, then read it.
    do_reset();
    frame(30'h1, 4'd1); tick();
    frame(30'h2, 4'd1); tick();
    idle();
    force dut.head_q = {1'b1, 4'd1, 30'h1};
    #1;
    chk("par_before", 32'(bus.parity_err), 0);
    bus.rd_ready = 1'b1;
    tick();
    release dut.head_q;
    chk("par_set", 32'(bus.parity_err), 1);
    tick();
    tick();
    chk("par_sticky", 32'(bus.parity_err), 1);
    do_reset();
    chk("par_cleared", 32'(bus.parity_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
